// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants for the single-port SRAM controller: stall/reset levels,
// controller state encoding and byte-enable patterns.
package mem_sram_ctrl_pkg;

  localparam logic STALL_YES   = 1'b1;
  localparam logic STALL_NO    = 1'b0;
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    D_SETUP  = 3'd1,
    D_STROBE = 3'd2,
    I_SETUP  = 3'd3,
    I_STROBE = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Active-low lane patterns: every lane enabled / every lane disabled.
  localparam logic [3:0] BE_ALL_N  = 4'b0000;
  localparam logic [3:0] BE_NONE_N = 4'b1111;

endpackage

// File: rtl/mem_sram_ctrl_chk.sv
// Bus-protocol properties for mem_sram_ctrl: no drive contention on the SRAM
// data bus, and the write strobe only ever appears in the data strobe state.
module mem_sram_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic sram_dq_oe,
  input logic sram_oe_n,
  input logic sram_we_n,
  input logic in_d_strobe
);

  // Controller and SRAM must never drive the data bus at the same time.
  a_no_contention: assert property (@(posedge clk) !(sram_dq_oe && !sram_oe_n));

  // A write pulse outside D_STROBE would corrupt memory.
  a_we_in_strobe: assert property (@(posedge clk) disable iff (!rst)
                                   !sram_we_n |-> in_d_strobe);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Single asynchronous SRAM shared by instruction fetch and data access. A data
// access always runs before a pending fetch inside one stall window.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce,
  input  logic [31:0]       if_addr,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       if_inst,
  output logic [31:0]       mem_rdata,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  state_t state_r;
  state_t state_nxt_s;
  logic   stall_s;
  logic   cap_d_s;
  logic   cap_i_s;
  logic   unused_s;

  // Byte-offset and upper address bits are not part of the SRAM word address.
  assign unused_s = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0],
                      if_addr[31:ADDR_W+2], if_addr[1:0]};

  // State register; reset drops straight back to IDLE, even mid-access.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state sequencing: data phase first, then fetch, then one DONE cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_ce) begin
          state_nxt_s = D_SETUP;
        end else if (if_ce) begin
          state_nxt_s = I_SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      D_SETUP:  state_nxt_s = D_STROBE;
      D_STROBE: begin
        if (if_ce) begin
          state_nxt_s = I_SETUP;
        end else begin
          state_nxt_s = DONE;
        end
      end
      I_SETUP:  state_nxt_s = I_STROBE;
      I_STROBE: state_nxt_s = DONE;
      DONE:     state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Strobe, address and bus-drive decode from the current state.
  always_comb begin
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = BE_NONE_N;
    stall_s    = STALL_NO;
    case (state_r)
      IDLE: begin
        if (mem_ce || if_ce) begin
          stall_s = STALL_YES;
        end else begin
          stall_s = STALL_NO;
        end
      end
      D_SETUP, D_STROBE: begin
        sram_addr = mem_addr[ADDR_W+1:2];
        sram_ce_n = 1'b0;
        stall_s   = STALL_YES;
        if (mem_we) begin
          // Write data is driven across both cycles; we_n pulses only in the strobe.
          sram_dq_oe = 1'b1;
          sram_dq_o  = DATA_W'(mem_wdata);
          sram_be_n  = ~mem_sel;
          if (state_r == D_STROBE) begin
            sram_we_n = 1'b0;
          end else begin
            sram_we_n = 1'b1;
          end
        end else begin
          sram_oe_n = 1'b0;
          sram_be_n = BE_ALL_N;
        end
      end
      I_SETUP, I_STROBE: begin
        sram_addr = if_addr[ADDR_W+1:2];
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = BE_ALL_N;
        stall_s   = STALL_YES;
      end
      DONE: begin
        stall_s = STALL_NO;
      end
      default: begin
        stall_s = STALL_NO;
      end
    endcase
  end

  // Requests held during reset must not stall the pipeline.
  assign stallreq_mem = (rst == RST_ENABLE) ? STALL_NO : stall_s;

  assign cap_d_s = (state_r == D_STROBE) && !mem_we;
  assign cap_i_s = (state_r == I_STROBE);

  // Read-data capture registers; each holds until its own next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      if_inst   <= 32'h0000_0000;
      mem_rdata <= 32'h0000_0000;
    end else begin
      if (cap_d_s) begin
        mem_rdata <= 32'(sram_dq_i);
      end
      if (cap_i_s) begin
        if_inst <= 32'(sram_dq_i);
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Randomized bench for mem_sram_ctrl: each request builds a list of bus phases
// from the access rules and every cycle is compared against that list.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  typedef enum {PH_IDLE, PH_DS, PH_DT, PH_IS, PH_IT, PH_DONE} phase_e;

  logic              clk;
  logic              rst;
  logic              if_ce;
  logic [31:0]       if_addr;
  logic              mem_ce;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_wdata;
  logic [31:0]       if_inst;
  logic [31:0]       mem_rdata;
  logic              stallreq_mem;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;
  logic              chk_d_strobe;

  int checks;
  int failures;
  logic [31:0] exp_rdata;
  logic [31:0] exp_inst;

  mem_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .if_ce(if_ce), .if_addr(if_addr),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .if_inst(if_inst), .mem_rdata(mem_rdata),
    .stallreq_mem(stallreq_mem), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  assign chk_d_strobe = (dut.state_r == D_STROBE);

  mem_sram_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .in_d_strobe(chk_d_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected combinational bus state for one phase, from the access rules.
  task automatic check_outputs(input phase_e ph);
    logic        e_ce_n, e_oe_n, e_we_n, e_oe, e_stall, chk_be, chk_dq;
    logic [19:0] e_addr;
    logic [3:0]  e_be;
    string       p;
    p = ph.name();
    e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_oe = 1'b0; e_stall = 1'b0;
    e_addr = 20'h0; e_be = 4'hF; chk_be = 1'b0; chk_dq = 1'b0;
    case (ph)
      PH_IDLE: e_stall = mem_ce | if_ce;
      PH_DS, PH_DT: begin
        e_addr = mem_addr[21:2]; e_ce_n = 1'b0; e_stall = 1'b1;
        if (mem_we) begin
          e_oe = 1'b1; e_be = ~mem_sel; chk_be = 1'b1; chk_dq = 1'b1;
          e_we_n = (ph == PH_DT) ? 1'b0 : 1'b1;
        end else begin
          e_oe_n = 1'b0;
        end
      end
      PH_IS, PH_IT: begin
        e_addr = if_addr[21:2]; e_ce_n = 1'b0; e_oe_n = 1'b0;
        e_be = 4'h0; chk_be = 1'b1; e_stall = 1'b1;
      end
      default: e_stall = 1'b0;
    endcase
    check_val({p, " ce_n"}, 64'(sram_ce_n), 64'(e_ce_n));
    check_val({p, " oe_n"}, 64'(sram_oe_n), 64'(e_oe_n));
    check_val({p, " we_n"}, 64'(sram_we_n), 64'(e_we_n));
    check_val({p, " dq_oe"}, 64'(sram_dq_oe), 64'(e_oe));
    check_val({p, " stall"}, 64'(stallreq_mem), 64'(e_stall));
    check_val({p, " addr"}, 64'(sram_addr), 64'(e_addr));
    if (chk_be) check_val({p, " be_n"}, 64'(sram_be_n), 64'(e_be));
    if (chk_dq) check_val({p, " dq_o"}, 64'(sram_dq_o), 64'(mem_wdata));
  endtask

  // One request window, entered just after a falling edge with the DUT in IDLE.
  task automatic run_txn(input logic m_ce, input logic m_we, input logic i_ce,
                         input logic [31:0] m_addr, input logic [31:0] i_addr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input logic fix_dq, input logic [31:0] dq_val);
    phase_e q[$];
    logic [31:0] dq;
    mem_ce = m_ce; mem_we = m_we; if_ce = i_ce;
    mem_addr = m_addr; if_addr = i_addr; mem_wdata = wdata; mem_sel = sel;
    q.push_back(PH_IDLE);
    if (m_ce) begin q.push_back(PH_DS); q.push_back(PH_DT); end
    if (i_ce) begin q.push_back(PH_IS); q.push_back(PH_IT); end
    if (m_ce || i_ce) q.push_back(PH_DONE);
    foreach (q[k]) begin
      dq = fix_dq ? dq_val : $urandom;
      sram_dq_i = dq;
      #1;
      check_outputs(q[k]);
      @(posedge clk);
      #1;
      if (q[k] == PH_DT && !m_we) exp_rdata = dq;
      if (q[k] == PH_IT) exp_inst = dq;
      check_val("mem_rdata", 64'(mem_rdata), 64'(exp_rdata));
      check_val("if_inst", 64'(if_inst), 64'(exp_inst));
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_rdata = 32'h0; exp_inst = 32'h0;
    rst = 1'b0; if_ce = 1'b1; mem_ce = 1'b1; mem_we = 1'b0; if_addr = 32'h0;
    mem_addr = 32'h0; mem_sel = 4'h0; mem_wdata = 32'h0; sram_dq_i = 32'h0;
    repeat (2) @(negedge clk);
    // Reset state, with requests held so the stall gating is exercised.
    check_val("rst ce_n", 64'(sram_ce_n), 64'd1);
    check_val("rst oe_n", 64'(sram_oe_n), 64'd1);
    check_val("rst we_n", 64'(sram_we_n), 64'd1);
    check_val("rst dq_oe", 64'(sram_dq_oe), 64'd0);
    check_val("rst addr", 64'(sram_addr), 64'd0);
    check_val("rst stall", 64'(stallreq_mem), 64'd0);
    check_val("rst inst", 64'(if_inst), 64'd0);
    check_val("rst rdata", 64'(mem_rdata), 64'd0);
    mem_ce = 1'b0; if_ce = 1'b0;
    rst = 1'b1;

    // Directed: fetch only, load + fetch, partial store, empty-lane store.
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'h2402_0005);
    check_val("fetch word", 64'(if_inst), 64'h2402_0005);
    run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 32'h0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0);
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0040, 32'h1234_5678, 4'b0000, 1'b0, 32'h0);

    // Ten quiet cycles stay idle with the SRAM deselected.
    repeat (10) run_txn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    // Reset in D_STROBE of a store, then restart with requests still held.
    mem_ce = 1'b1; mem_we = 1'b1; if_ce = 1'b1; mem_addr = 32'h0000_0404;
    if_addr = 32'h0000_0080; mem_wdata = 32'hCAFE_F00D; mem_sel = 4'b1111;
    sram_dq_i = $urandom;
    #1 check_outputs(PH_IDLE);
    @(negedge clk);
    #1 check_outputs(PH_DS);
    @(posedge clk);
    #2 check_outputs(PH_DT);
    rst = 1'b0;
    #1;
    exp_rdata = 32'h0; exp_inst = 32'h0;
    check_val("midrst ce_n", 64'(sram_ce_n), 64'd1);
    check_val("midrst we_n", 64'(sram_we_n), 64'd1);
    check_val("midrst dq_oe", 64'(sram_dq_oe), 64'd0);
    check_val("midrst stall", 64'(stallreq_mem), 64'd0);
    check_val("midrst addr", 64'(sram_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0404, 32'h0000_0080, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0);

    // Random mix of loads, stores, fetches and idle windows.
    repeat (80) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_ce  in  1  instruction fetch request, held until stall released.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 mem_ce  in  1  data access request from MEM stage.
REQ-008 mem_we  in  1  1 = store, 0 = load.
REQ-009 mem_addr  in  32  data byte address.
REQ-010 mem_sel  in  4  byte-lane enables, bit i = byte i.
REQ-011 mem_wdata  in  32  store data.
REQ-012 if_inst  out  32  fetched word, registered.
REQ-013 mem_rdata  out  32  loaded word, registered, unextended.
REQ-014 stallreq_mem  out  1  StallYes while any accepted request is incomplete; feeds stall_ctrl.
REQ-015 sram_addr  out  ADDR_W  word address.
REQ-016 sram_dq_o  out  DATA_W  write data.
REQ-017 sram_dq_i  in  DATA_W  read data.
REQ-018 sram_dq_oe  out  1  data bus drive enable.
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
REQ-020 sram_be_n  out  4  active-low byte enables.

Function
REQ-021 Single SRAM shared by fetch and data; data access SHALL precede fetch in the same stall window.
REQ-022 States SHALL be IDLE, D_SETUP, D_STROBE, I_SETUP, I_STROBE, DONE.
REQ-023 IDLE: mem_ce -> D_SETUP; else if_ce -> I_SETUP; else stay.
REQ-024 D_SETUP -> D_STROBE unconditionally.
REQ-025 D_STROBE: if_ce -> I_SETUP; else DONE.
REQ-026 I_SETUP -> I_STROBE -> DONE unconditionally.
REQ-027 DONE -> IDLE unconditionally; requests seen in DONE are not accepted until IDLE.
REQ-028 stallreq_mem SHALL be StallYes in IDLE with (if_ce|mem_ce) and in every SETUP/STROBE state, StallNo in DONE and in idle IDLE.
REQ-029 Latency: fetch-only 4 cycles IDLE-to-DONE inclusive; load/store+fetch 6 cycles; data-only 4 cycles.
REQ-030 sram_addr SHALL be mem_addr[ADDR_W+1:2] in D_*, if_addr[ADDR_W+1:2] in I_*, 0 otherwise.
REQ-031 sram_ce_n low in all SETUP/STROBE states, high elsewhere.
REQ-032 Load: sram_oe_n low in D_SETUP/D_STROBE; mem_rdata SHALL capture sram_dq_i on the D_STROBE->next edge.
REQ-033 Store: sram_dq_oe high and sram_dq_o = mem_wdata in D_SETUP/D_STROBE; sram_we_n low only in D_STROBE; sram_be_n = ~mem_sel; sram_oe_n high.
REQ-034 Fetch: sram_oe_n low, sram_be_n = 4'b0000, if_inst captures sram_dq_i on I_STROBE->DONE edge.
REQ-035 sram_dq_oe SHALL never be high while sram_oe_n is low.
REQ-036 mem_rdata/if_inst SHALL hold value until next capture; store SHALL leave mem_rdata unchanged.
REQ-037 mem_sel = 0 on store SHALL still run full cycle with all be_n high (no write).

Reset
REQ-038 rst low SHALL force IDLE immediately, mid-access included; strobes high, sram_dq_oe 0, sram_addr 0, stallreq_mem StallNo, if_inst 0, mem_rdata 0.
REQ-039 First edge after rst release SHALL evaluate REQ-023 normally.

Structure
REQ-040 StallYes/StallNo, RstEnable/RstDisable and state encodings SHALL live in shared defines.v.
REQ-041 SHALL be one flat module: one state register, two data registers, combinational strobe decode; no sub-module.

Verification
REQ-042 if_ce=1, if_addr=0x0000_0010, sram_dq_i=0x2402_0005 -> stall high 3 cycles, DONE sram_addr idle, if_inst=0x2402_0005, sram_addr=0x00004 during I_*.
REQ-043 mem_ce=1,mem_we=0,mem_addr=0x0000_0100 plus if_ce -> D then I phases, stall high 5 cycles, mem_rdata=D-phase bus value, sram_addr 0x00040 then fetch address.
REQ-044 Store mem_addr=0x0000_0204,mem_sel=4'b0011,wdata=0xDEAD_BEEF -> sram_addr=0x00081, be_n=4'b1100, we_n low exactly 1 cycle, dq_oe high 2 cycles.
REQ-045 rst low during D_STROBE -> same-cycle strobes high, dq_oe 0, stall StallNo; after release with requests held, sequence restarts at D_SETUP.
REQ-046 No requests for 10 cycles -> IDLE, stall StallNo, ce_n high throughout.
REQ-047 Assertion every cycle: !(sram_dq_oe && !sram_oe_n); we_n low implies state D_STROBE.
